// File: rtl/dmem_arbiter_if.sv
// Bundle of per-core data-memory request/response signals plus the shared memory port.
// The arbiter uses the slave view; the cores and the RAM together form the master view.
interface dmem_arbiter_if #(
    parameter int N_CORES = 4,
    parameter int AW      = 16,
    parameter int DW      = 16
);
    logic [N_CORES-1:0]    core_rd;
    logic [N_CORES-1:0]    core_wr;
    logic [N_CORES*AW-1:0] core_addr;
    logic [N_CORES*DW-1:0] core_wdata;
    logic [DW-1:0]         core_rdata;
    logic [N_CORES-1:0]    core_ack;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_wdata;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [DW-1:0]         mem_rdata;

    modport master (
        output core_rd, core_wr, core_addr, core_wdata, mem_rdata,
        input  core_rdata, core_ack, mem_addr, mem_wdata, mem_rd, mem_wr
    );

    modport slave (
        input  core_rd, core_wr, core_addr, core_wdata, mem_rdata,
        output core_rdata, core_ack, mem_addr, mem_wdata, mem_rd, mem_wr
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one single-port data RAM between N_CORES cores, one 4-cycle transaction at a time.
// Define DMEM_ARB_RR_EN for round-robin selection; otherwise the lowest requesting index wins.
module dmem_arbiter #(
    parameter int N_CORES = 4,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    dmem_arbiter_if.slave              bus,
    output logic [$clog2(N_CORES)-1:0] grant_id,
    output logic                       busy
);
    localparam int GW = $clog2(N_CORES);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, ACK} state_e;

    state_e         state_q, state_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic           op_wr_q, op_wr_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [DW-1:0]  rdata_q, rdata_d;

    logic [N_CORES-1:0] req;
    logic               win_found;
    logic [GW-1:0]      win_idx;
    logic [GW-1:0]      cand;

`ifdef DMEM_ARB_RR_EN
    logic [GW-1:0] p_q, p_d;

    function automatic logic [GW-1:0] rr_index(input logic [GW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= N_CORES) sum = sum - N_CORES;
        return GW'(sum);
    endfunction
`endif

    // Winner scan starts at the priority pointer (round-robin) or at index 0 (fixed).
    always_comb begin
        req       = bus.core_rd | bus.core_wr;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_CORES; k++) begin
`ifdef DMEM_ARB_RR_EN
            cand = rr_index(p_q, k);
`else
            cand = GW'(k);
`endif
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef DMEM_ARB_RR_EN
        p_d     = p_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = ISSUE;
                    grant_d = win_idx;
                    op_wr_d = bus.core_wr[win_idx];
                    addr_d  = bus.core_addr[int'(win_idx)*AW +: AW];
                    wdata_d = bus.core_wdata[int'(win_idx)*DW +: DW];
                end
            end
            ISSUE: state_d = CAPT;
            CAPT: begin
                if (!op_wr_q) rdata_d = bus.mem_rdata;
                state_d = ACK;
            end
            ACK: begin
`ifdef DMEM_ARB_RR_EN
                p_d = (int'(grant_q) == N_CORES - 1) ? '0 : grant_q + 1'b1;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
            p_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef DMEM_ARB_RR_EN
            p_q     <= p_d;
`endif
        end
    end

    // The latches only change on acceptance/capture, so the memory bus and read data hold between uses.
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.core_rdata = rdata_q;
    assign bus.mem_rd     = (state_q == ISSUE) && !op_wr_q;
    assign bus.mem_wr     = (state_q == ISSUE) && op_wr_q;
    assign grant_id       = grant_q;
    assign busy           = (state_q != IDLE);

    always_comb begin
        bus.core_ack = '0;
        if (state_q == ACK) bus.core_ack[grant_q] = 1'b1;
    end
endmodule
